fifo_wr_arbiter: RTL and testbench

Round-robin write-side arbiter for the 8-bit synchronous FIFO. Several independent producers share the FIFO write port through it. The block grants one producer at a time for a bounded burst, forwards that producer's data straight into the FIFO's `write_en`/`data_in`, and stalls the producer on `full`. It sits directly in front of `fifo_top` and owns that FIFO's write port exclusively.

---
 rtl/fifo_wr_arbiter_pkg.sv | 22 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 39 +++
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and constants for the FIFO write-side arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_t;

   localparam int c_DEFAULT_DATA_W = 8;

   // Index width for a requester vector; a single requester still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_wr_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin picker, first request above 'last'.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_pick
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic               found,
   output logic [IDX_W-1:0]   idx
);

   int w_best;
   int w_dist;

   // Smallest forward distance from last+1 (mod NUM_REQ) wins.
   always_comb begin
      found  = 1'b0;
      idx    = '0;
      w_best = NUM_REQ;
      w_dist = 0;
      for (int c = 0; c < NUM_REQ; c++) begin
         w_dist = (c + 2 * NUM_REQ - int'(last) - 1) % NUM_REQ;
         if (req[c] && (w_dist < w_best)) begin
            w_best = w_dist;
            found  = 1'b1;
            idx    = IDX_W'(c);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin burst arbiter driving the write port of a FIFO.
//  Revision    : 1.0  initial release
// ============================================================================
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = c_DEFAULT_DATA_W,
   parameter int MAX_BURST = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   input  logic                        fifo_full,
   output logic                        fifo_write_en,
   output logic [DATA_W-1:0]           fifo_data_in,
   output logic [idx_w(NUM_REQ)-1:0]   grant_id,
   output logic                        busy
);

   localparam int c_IDX_W  = idx_w(NUM_REQ);
   localparam int c_BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(MAX_BURST - 1);

   arb_state_t            r_state;
   logic [c_IDX_W-1:0]    r_gnt;
   logic [c_IDX_W-1:0]    r_last_gnt;
   logic [c_BEAT_W-1:0]   r_beat_cnt;
   logic                  r_busy;

   logic                  w_found;
   logic [c_IDX_W-1:0]    w_pick;
   logic                  w_sel_valid;
   logic                  w_xfer;
   logic                  w_release;
   logic [DATA_W-1:0]     w_slice [NUM_REQ];

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
      assign w_slice[i] = req_data[i*DATA_W +: DATA_W];
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (c_IDX_W)
   ) u_rr_pick (
      .req   (req_valid),
      .last  (r_last_gnt),
      .found (w_found),
      .idx   (w_pick)
   );

   assign w_sel_valid = req_valid[r_gnt];
   // fifo_full gates the write in the same cycle, so the FIFO can never overflow.
   assign w_xfer      = (r_state == GRANT) && w_sel_valid && !fifo_full;
   assign w_release   = (w_xfer && (r_beat_cnt == c_LAST_BEAT))
                     || (!w_sel_valid && !fifo_full);

   assign fifo_write_en = w_xfer;
   assign fifo_data_in  = w_slice[r_gnt];
   assign grant_id      = r_gnt;
   assign busy          = r_busy;

   always_comb begin
      req_ready = '0;
      if ((r_state == GRANT) && !fifo_full)
         req_ready[r_gnt] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= IDLE;
         r_gnt      <= '0;
         r_last_gnt <= c_IDX_W'(NUM_REQ - 1);
         r_beat_cnt <= '0;
         r_busy     <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_found) begin
                  r_gnt      <= w_pick;
                  r_last_gnt <= w_pick;
                  r_beat_cnt <= '0;
                  r_state    <= GRANT;
                  r_busy     <= 1'b1;
               end
            end
            GRANT: begin
               if (w_release) begin
                  r_beat_cnt <= '0;
                  r_state    <= IDLE;
                  r_busy     <= 1'b0;
               end else if (w_xfer) begin
                  r_beat_cnt <= r_beat_cnt + 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Directed bench for fifo_wr_arbiter with a depth-8 FIFO model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ   = 4;
   localparam int DATA_W    = 8;
   localparam int MAX_BURST = 4;

   logic                      clk = 1'b0;
   logic                      rst = 1'b0;
   logic [NUM_REQ-1:0]        req_valid = '0;
   logic [NUM_REQ*DATA_W-1:0] req_data  = '0;
   logic [NUM_REQ-1:0]        req_ready;
   logic                      fifo_full;
   logic                      fifo_write_en;
   logic [DATA_W-1:0]         fifo_data_in;
   logic [1:0]                grant_id;
   logic                      busy;

   logic                      ext_full = 1'b0;
   logic                      rd_en    = 1'b0;
   logic [DATA_W-1:0]         mem [8];
   logic [2:0]                wp = '0;
   logic [2:0]                rp = '0;
   logic [3:0]                cnt = '0;
   logic [DATA_W-1:0]         rd_data = '0;
   int                        wcnt = 0;
   int                        ovf  = 0;

   int passed = 0;
   int failed = 0;
   int total  = 0;
   int w0     = 0;
   int nxt    = 0;
   logic acc;

   always #5 clk = ~clk;

   assign fifo_full = ext_full | (cnt == 4'd8);

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .fifo_full     (fifo_full),
      .fifo_write_en (fifo_write_en),
      .fifo_data_in  (fifo_data_in),
      .grant_id      (grant_id),
      .busy          (busy)
   );

   // Depth-8 synchronous FIFO standing in for fifo_top.
   always @(posedge clk) begin
      if (fifo_write_en && fifo_full) ovf <= ovf + 1;
      if (fifo_write_en && !fifo_full) begin
         mem[wp] <= fifo_data_in;
         wp      <= wp + 3'd1;
         wcnt    <= wcnt + 1;
      end
      if (rd_en && (cnt != 4'd0)) begin
         rd_data <= mem[rp];
         rp      <= rp + 3'd1;
      end
      cnt <= cnt + 4'(fifo_write_en && !fifo_full) - 4'(rd_en && (cnt != 4'd0));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else begin
         failed = failed + 1;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_data(input int i, input logic [7:0] v);
      req_data[i*DATA_W +: DATA_W] = v;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #2;
      chk("rst ready", 32'(req_ready), 0);
      chk("rst wr", 32'(fifo_write_en), 0);
      chk("rst gid", 32'(grant_id), 0);
      chk("rst busy", 32'(busy), 0);
      tick();
      tick();
      rst = 1'b1;

      // Single producer 1, bursts of 4 then 2
      req_valid = 4'b0010;
      set_data(1, 8'h11);
      #2;
      chk("A idle busy", 32'(busy), 0);
      chk("A idle wr", 32'(fifo_write_en), 0);
      tick();
      for (int k = 0; k < 4; k++) begin
         #2;
         chk("A gid", 32'(grant_id), 1);
         chk("A ready", 32'(req_ready), 32'h2);
         chk("A wr", 32'(fifo_write_en), 1);
         chk("A data", 32'(fifo_data_in), 32'h11 + k);
         tick();
         set_data(1, 8'(8'h12 + k));
      end
      #2;
      chk("A bubble busy", 32'(busy), 0);
      chk("A bubble wr", 32'(fifo_write_en), 0);
      chk("A bubble ready", 32'(req_ready), 0);
      tick();
      for (int k = 0; k < 2; k++) begin
         #2;
         chk("A2 gid", 32'(grant_id), 1);
         chk("A2 wr", 32'(fifo_write_en), 1);
         chk("A2 data", 32'(fifo_data_in), 32'h15 + k);
         tick();
         if (k == 0) set_data(1, 8'h16);
         else req_valid = '0;
      end
      #2;
      chk("A drop wr", 32'(fifo_write_en), 0);
      chk("A drop busy", 32'(busy), 1);
      tick();
      #2;
      chk("A released", 32'(busy), 0);
      rd_en = 1'b1;
      for (int k = 0; k < 6; k++) begin
         tick();
         #2;
         chk("A readback", 32'(rd_data), 32'h11 + k);
      end

      // Reset mid-burst: producer 2, beat 2
      req_valid = 4'b0100;
      set_data(2, 8'h31);
      tick();
      #2;
      chk("R gid", 32'(grant_id), 2);
      chk("R data0", 32'(fifo_data_in), 32'h31);
      tick();
      set_data(2, 8'h32);
      #2;
      chk("R wr1", 32'(fifo_write_en), 1);
      tick();
      set_data(2, 8'h33);
      #2;
      chk("R wr2", 32'(fifo_write_en), 1);
      w0 = wcnt;
      rst = 1'b0;
      #1;
      chk("R async wr", 32'(fifo_write_en), 0);
      chk("R async ready", 32'(req_ready), 0);
      chk("R async busy", 32'(busy), 0);
      chk("R async gid", 32'(grant_id), 0);
      tick();
      #2;
      chk("R no write", wcnt - w0, 0);
      req_valid = 4'hF;
      for (int i = 0; i < NUM_REQ; i++) set_data(i, 8'(8'hA0 + i));
      rst = 1'b1;
      chk("R idle busy", 32'(busy), 0);
      tick();

      // Fairness: grants 0,1,2,3,0 with 4 beats each and a one-cycle bubble
      for (int gi = 0; gi < 5; gi++) begin
         for (int b = 0; b < MAX_BURST; b++) begin
            #2;
            chk("F gid", 32'(grant_id), 32'(gi % 4));
            chk("F busy", 32'(busy), 1);
            chk("F wr", 32'(fifo_write_en), 1);
            chk("F data", 32'(fifo_data_in), 32'hA0 + (gi % 4));
            tick();
         end
         #2;
         chk("F bubble busy", 32'(busy), 0);
         chk("F bubble wr", 32'(fifo_write_en), 0);
         if (gi == 4) req_valid = '0;
         tick();
      end

      // Full stall after beat 2 of producer 0
      req_valid = 4'b0001;
      set_data(0, 8'h01);
      #2;
      chk("S idle", 32'(busy), 0);
      tick();
      #2;
      chk("S gid", 32'(grant_id), 0);
      chk("S data1", 32'(fifo_data_in), 32'h01);
      chk("S wr1", 32'(fifo_write_en), 1);
      tick();
      set_data(0, 8'h02);
      #2;
      chk("S data2", 32'(fifo_data_in), 32'h02);
      chk("S wr2", 32'(fifo_write_en), 1);
      tick();
      set_data(0, 8'h03);
      ext_full = 1'b1;
      for (int s = 0; s < 3; s++) begin
         req_valid = (s == 1) ? 4'b0000 : 4'b0001;
         #2;
         chk("S stall wr", 32'(fifo_write_en), 0);
         chk("S stall ready", 32'(req_ready), 0);
         chk("S stall gid", 32'(grant_id), 0);
         chk("S stall busy", 32'(busy), 1);
         chk("S stall beat", 32'(dut.r_beat_cnt), 2);
         tick();
      end
      ext_full  = 1'b0;
      req_valid = 4'b0001;
      #2;
      chk("S data3", 32'(fifo_data_in), 32'h03);
      chk("S wr3", 32'(fifo_write_en), 1);
      tick();
      set_data(0, 8'h04);
      #2;
      chk("S data4", 32'(fifo_data_in), 32'h04);
      chk("S wr4", 32'(fifo_write_en), 1);
      tick();
      req_valid = '0;
      #2;
      chk("S released", 32'(busy), 0);

      // Early release of producer 0; next grant must be 2
      req_valid = 4'b0001;
      set_data(0, 8'h21);
      tick();
      req_valid = 4'b1101;
      set_data(2, 8'hC2);
      set_data(3, 8'hC3);
      #2;
      chk("E gid0", 32'(grant_id), 0);
      chk("E ready0", 32'(req_ready), 32'h1);
      chk("E data1", 32'(fifo_data_in), 32'h21);
      tick();
      set_data(0, 8'h22);
      #2;
      chk("E data2", 32'(fifo_data_in), 32'h22);
      tick();
      req_valid = 4'b1100;
      #2;
      chk("E drop wr", 32'(fifo_write_en), 0);
      tick();
      #2;
      chk("E release", 32'(busy), 0);
      tick();
      req_valid = '0;
      #2;
      chk("E next gid", 32'(grant_id), 2);
      chk("E next busy", 32'(busy), 1);
      tick();

      // No overflow: producer 3 offers 1..10 into an undrained depth-8 FIFO
      rd_en = 1'b0;
      #2;
      chk("O empty", 32'(cnt), 0);
      w0 = wcnt;
      nxt = 1;
      req_valid = 4'b1000;
      set_data(3, 8'(nxt));
      for (int c = 0; c < 30; c++) begin
         #2;
         acc = req_ready[3] && req_valid[3];
         tick();
         if (acc && (nxt < 10)) begin
            nxt = nxt + 1;
            set_data(3, 8'(nxt));
         end
      end
      #2;
      chk("O written", wcnt - w0, 8);
      chk("O overflow", ovf, 0);
      chk("O full", 32'(fifo_full), 1);
      chk("O stalled wr", 32'(fifo_write_en), 0);
      chk("O gid", 32'(grant_id), 3);
      req_valid = '0;
      rd_en = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         #2;
         chk("O readback", 32'(rd_data), 32'(k));
      end
      rd_en = 1'b0;
      chk("O final written", wcnt - w0, 8);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
